// File: rtl/databus_arbiter.sv
// Round-robin owner arbiter for the shared DataBus/address bus: one owner at a time,
// a one-cycle turnaround gap between owners, and a hold-time watchdog.
module databus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Done,
    output logic [NUM_REQ-1:0] Grant,
    output logic [ID_W-1:0]    GrantId,
    output logic               BusBusy,
    output logic               Timeout
);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic [ID_W-1:0]    win, win_hi, win_lo, next_ptr;
    logic               found_hi, found_lo, any_req, release_own, watchdog;

    // Round-robin pick: first requester at or above the pointer, else the lowest one (wrap).
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (Req[j] && !found_hi && (j >= int'(ptr_q))) begin
                found_hi = 1'b1;
                win_hi   = ID_W'(j);
            end
            if (Req[j] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = ID_W'(j);
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    assign any_req     = |Req;
    assign release_own = (|(Done & grant_q)) || !(|(Req & grant_q));
    assign watchdog    = (MAX_HOLD > 0) && (cnt_q == CNT_W'(MAX_HOLD));
    assign next_ptr    = (int'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + ID_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gid_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: state_d = any_req ? OWN : IDLE;
            OWN:       if (release_own || watchdog) state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                grant_d = '0;
                if (any_req) begin
                    grant_d = NUM_REQ'(1) << win;
                    gid_d   = win;
                    cnt_d   = CNT_W'(1);
                end
            end
            OWN: begin
                // A release on the same edge as the watchdog wins, so no Timeout pulse.
                if (release_own || watchdog) begin
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    cnt_d     = '0;
                    timeout_d = !release_own;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: grant_d = '0;
        endcase
        busy_d = |grant_d;
    end

    assign Grant   = grant_q;
    assign GrantId = gid_q;
    assign BusBusy = busy_q;
    assign Timeout = timeout_q;
endmodule
